// File: rtl/desrotaciona_linhas.sv
// AES inverse row rotation (forward too with ROTACAO_BIDIRECIONAL_EN), one row rewritten per cycle.
// Latency: accept at edge k, saida_valida high after edge k+4; no combinational bloco->saida path.
// Backpressure: result held in PRONTO until saida_pronta; entrada_pronta only in OCIOSO.
module desrotaciona_linhas (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] bloco,
  input  logic         entrada_valida,
  output logic         entrada_pronta,
  output logic [127:0] saida,
  output logic         saida_valida,
  input  logic         saida_pronta,
`ifdef ROTACAO_BIDIRECIONAL_EN
  input  logic         modo,
`endif
  output logic         ocupado
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    PROCESSA = 2'd1,
    PRONTO   = 2'd2
  } estado_t;

  estado_t        estado_q, estado_d;
  logic [127:0]   trab_q, trab_d;
  logic [127:0]   saida_q, saida_d;
  logic [1:0]     linha_q, linha_d;
  logic [127:0]   trab_novo;
  logic           direto;

  // Rotate a 32-bit row by r bytes; column 0 sits in the MSB byte.
  function automatic logic [31:0] gira(input logic [31:0] w, input logic [1:0] r,
                                       input logic fwd);
    logic [31:0] o;
    case (r)
      2'd1:    o = fwd ? {w[23:0], w[31:24]} : {w[7:0], w[31:8]};
      2'd2:    o = {w[15:0], w[31:16]};
      2'd3:    o = fwd ? {w[7:0], w[31:8]} : {w[23:0], w[31:24]};
      default: o = w;
    endcase
    return o;
  endfunction

`ifdef ROTACAO_BIDIRECIONAL_EN
  logic modo_q, modo_d;

  always_comb begin
    modo_d = modo_q;
    if (estado_q == OCIOSO && entrada_valida)
      modo_d = modo;
  end

  always_ff @(posedge clk) begin
    if (rst) modo_q <= 1'b0;
    else     modo_q <= modo_d;
  end

  assign direto = modo_q;
`else
  assign direto = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) estado_q <= OCIOSO;
    else     estado_q <= estado_d;
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:   if (entrada_valida) estado_d = PROCESSA;
      PROCESSA: if (linha_q == 2'd3) estado_d = PRONTO;
      PRONTO:   if (saida_pronta) estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
  end

  // Output logic
  always_comb begin
    entrada_pronta = 1'b0;
    ocupado        = 1'b0;
    saida_valida   = 1'b0;
    case (estado_q)
      OCIOSO:   entrada_pronta = 1'b1;
      PROCESSA: ocupado        = 1'b1;
      PRONTO:   saida_valida   = 1'b1;
      default:  entrada_pronta = 1'b0;
    endcase
  end

  assign saida = saida_q;

  // Working register with only the row selected by linha_q rewritten.
  always_comb begin
    trab_novo = trab_q;
    for (int r = 0; r < 4; r++) begin
      if (linha_q == 2'(r))
        trab_novo[127-32*r -: 32] = gira(trab_q[127-32*r -: 32], 2'(r), direto);
    end
  end

  always_comb begin
    trab_d  = trab_q;
    linha_d = linha_q;
    saida_d = saida_q;
    case (estado_q)
      OCIOSO: begin
        if (entrada_valida) begin
          trab_d  = bloco;
          linha_d = 2'd0;
        end
      end
      PROCESSA: begin
        trab_d  = trab_novo;
        linha_d = linha_q + 2'd1;
        if (linha_q == 2'd3)
          saida_d = trab_novo;
      end
      default: begin
        trab_d = trab_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trab_q  <= '0;
      linha_q <= 2'd0;
      saida_q <= '0;
    end else begin
      trab_q  <= trab_d;
      linha_q <= linha_d;
      saida_q <= saida_d;
    end
  end

endmodule

// File: doc/desrotaciona_linhas.md
DESROTACIONA_LINHAS -- requirements
Module: desrotaciona_linhas

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port bloco  input  128  state block, row-major: row r = bits [127-32r : 96-32r], column 0 in the MSB byte of each row.
REQ-004 SHALL have port entrada_valida  input  1  bloco is valid this cycle.
REQ-005 SHALL have port entrada_pronta  output  1  block ready to accept an input.
REQ-006 SHALL have port saida  output  128  result block, same row-major layout.
REQ-007 SHALL have port saida_valida  output  1  saida holds a finished result.
REQ-008 SHALL have port saida_pronta  input  1  consumer accepts saida.
REQ-009 SHALL have port ocupado  output  1  high while in PROCESSA.

Function
REQ-010 SHALL implement the AES inverse row rotation, applied one row per cycle: row r rotated right by r bytes, i.e. byte at column c moves to column (c+r) mod 4.
REQ-011 SHALL use FSM states OCIOSO, PROCESSA, PRONTO.
REQ-012 SHALL assert entrada_pronta only in OCIOSO, and leave it low in PROCESSA and PRONTO.
REQ-013 SHALL accept on any edge with entrada_valida=1 and entrada_pronta=1; on that edge it captures bloco into the working register, clears the 2-bit row counter to 0, and moves OCIOSO->PROCESSA.
REQ-014 SHALL, in PROCESSA, rewrite the row selected by the row counter on each edge, then increment the counter.
REQ-015 SHALL move PROCESSA->PRONTO on the edge where the counter equals 3; the counter wraps to 0 on that edge.
REQ-016 SHALL have fixed latency: acceptance at edge k gives saida_valida=1 in the cycle following edge k+4.
REQ-017 SHALL hold saida_valida=1 and saida stable in PRONTO until an edge with saida_pronta=1, which moves PRONTO->OCIOSO.
REQ-018 SHALL NOT accept a new input on the same edge as the output handshake; the earliest next acceptance is one edge later.
REQ-019 SHALL ignore entrada_valida outside OCIOSO; it SHALL NOT modify bloco or the counter there.
REQ-020 SHALL leave row 0 unchanged; row 0's cycle still counts toward latency.
REQ-021 SHALL have no combinational path from bloco to saida.

Reset
REQ-022 SHALL, on any edge with rst=1, force state OCIOSO, counter 0, working register 0, and outputs saida=0, saida_valida=0, ocupado=0, entrada_pronta=1 from the next cycle.
REQ-023 SHALL discard any in-flight block when rst is asserted in PROCESSA or PRONTO, with no partial result visible afterwards.
REQ-024 SHALL give rst priority over every handshake on the same edge.

Configuration
REQ-025 SHALL, when macro ROTACAO_BIDIRECIONAL_EN is defined, add input port modo (1 bit), captured at acceptance: modo=0 selects inverse rotation per REQ-010; modo=1 selects forward rotation (row r rotated left by r bytes). Latency and handshake are unchanged.
REQ-026 SHALL, without ROTACAO_BIDIRECIONAL_EN, omit the modo port and always perform inverse rotation.

Verification
REQ-027 SHALL cover basic inverse rotation: bloco=00112233_44556677_8899AABB_CCDDEEFF, saida_pronta=1 -> saida=00112233_77445566_AABB8899_DDEEFFCC, with saida_valida first high 5 cycles after acceptance.
REQ-028 SHALL cover backpressure: saida_pronta=0 for 10 cycles after saida_valida -> saida, saida_valida and entrada_pronta=0 stay constant; release leads to OCIOSO on the next edge.
REQ-029 SHALL cover ignored input: entrada_valida held high with a different bloco during PROCESSA -> result is unchanged from REQ-027.
REQ-030 SHALL cover reset mid-operation: rst=1 at the 2nd PROCESSA edge -> next cycle saida=0, saida_valida=0, entrada_pronta=1; a following block yields a correct result.
REQ-031 SHALL cover the forward direction with ROTACAO_BIDIRECIONAL_EN and modo=1: same bloco -> saida=00112233_55667744_AABB8899_FFCCDDEE.
REQ-032 SHALL cover the round trip: a forward result fed back with modo=0 -> original bloco restored, over 100 random blocks.
